fifo_serializer: RTL and testbench

// - Downstream consumer of the P_S FIFO: pops parallel words and shifts them out one bit per accepted beat.
// - Serial side uses a valid/ready handshake; the FIFO side drives rd_en and samples the FIFO's registered dout.
// - Prefetches the next word during the tail of the current word, so back-to-back words stream with no gap bit.

---
 rtl/fifo_serializer_pkg.sv | 12 +
 rtl/fifo_serializer_if.sv | 25 ++
 rtl/fifo_serializer_piso_shreg.sv | 38 +++
 rtl/fifo_serializer.sv | 117 +++++++++++
 tb/tb_fifo_serializer.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_serializer_pkg.sv
// Shared types and defaults for the FIFO-to-serial path.
package p_s_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2
    } ser_state_t;

endpackage

// File: rtl/fifo_serializer_if.sv
// FIFO read port plus serial valid/ready port of the serializer.
interface fifo_serializer_if
    import p_s_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic                  ser_data;
    logic                  ser_valid;
    logic                  ser_ready;
    logic                  ser_last;
    logic                  busy;

    modport master (
        input  fifo_dout, fifo_empty, ser_ready,
        output fifo_rd_en, ser_data, ser_valid, ser_last, busy
    );

    modport slave (
        output fifo_dout, fifo_empty, ser_ready,
        input  fifo_rd_en, ser_data, ser_valid, ser_last, busy
    );
endinterface

// File: rtl/fifo_serializer_piso_shreg.sv
// Parallel-in serial-out register: load wins over shift, vacated bits fill with zero.
module piso_shreg #(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  dout
);
    logic [DATA_WIDTH-1:0] shreg_q;
    logic [DATA_WIDTH-1:0] shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = din;
        end else if (shift) begin
            if (MSB_FIRST) begin
                shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
            end else begin
                shreg_d = {1'b0, shreg_q[DATA_WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign dout = MSB_FIRST ? shreg_q[DATA_WIDTH-1] : shreg_q[0];
endmodule

// File: rtl/fifo_serializer.sv
// Pops words from a registered-output FIFO and streams them bit by bit,
// prefetching the next word near the end of the current one for gapless output.
module fifo_serializer
    import p_s_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter bit MSB_FIRST  = 1'b1
) (
    input logic               clk,
    input logic               rst,
    fifo_serializer_if.master bus
);
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] PF_IDX   = CNT_W'(DATA_WIDTH - 2);

    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_FETCH = 2'(FETCH);
    localparam logic [1:0] ST_SHIFT = 2'(SHIFT);

    logic [1:0]       state_q,   state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             pf_pend_q, pf_pend_d;

    logic accept;
    logic last_bit;
    logic idle_rd;
    logic pf_issue;
    logic sh_load;
    logic sh_shift;
    logic sh_dout;

    assign bus.ser_valid = (state_q == ST_SHIFT);
    assign accept        = bus.ser_valid && bus.ser_ready;
    assign last_bit      = (bit_cnt_q == LAST_IDX);
    assign idle_rd       = (state_q == ST_IDLE) && !bus.fifo_empty;
    // Only one read may be in flight; the FIFO holds its dout until the next pop.
    assign pf_issue      = (state_q == ST_SHIFT) && !pf_pend_q && !bus.fifo_empty
                           && (bit_cnt_q >= PF_IDX);

    assign bus.fifo_rd_en = !rst && (idle_rd || pf_issue);
    assign bus.ser_last   = bus.ser_valid && last_bit;
    assign bus.ser_data   = sh_dout;
    assign bus.busy       = (state_q != ST_IDLE) || pf_pend_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        pf_pend_d = pf_pend_q;
        sh_load   = 1'b0;
        sh_shift  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (idle_rd) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                sh_load   = 1'b1;
                bit_cnt_d = '0;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (pf_issue) begin
                    pf_pend_d = 1'b1;
                end
                if (accept) begin
                    if (last_bit) begin
                        bit_cnt_d = '0;
                        if (pf_pend_q) begin
                            // Earlier read has already landed in fifo_dout.
                            sh_load   = 1'b1;
                            pf_pend_d = 1'b0;
                        end else if (pf_issue) begin
                            sh_shift  = 1'b1;
                            pf_pend_d = 1'b0;
                            state_d   = ST_FETCH;
                        end else begin
                            sh_shift = 1'b1;
                            state_d  = ST_IDLE;
                        end
                    end else begin
                        sh_shift  = 1'b1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            pf_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            pf_pend_q <= pf_pend_d;
        end
    end

    piso_shreg #(
        .DATA_WIDTH (DATA_WIDTH),
        .MSB_FIRST  (MSB_FIRST)
    ) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (sh_load),
        .shift (sh_shift),
        .din   (bus.fifo_dout),
        .dout  (sh_dout)
    );
endmodule

// File: tb/tb_fifo_serializer.sv
// Directed bench: a queue-based FIFO feeds MSB-first and LSB-first serializers;
// a bit-stream model predicts every serial beat.
module tb_fifo_serializer;
    import p_s_pkg::*;

    localparam int DW = 8;

    typedef struct packed {
        logic b;
        logic l;
    } ebit_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_serializer_if #(.DATA_WIDTH(DW)) bus   ();
    fifo_serializer_if #(.DATA_WIDTH(DW)) bus_l ();

    fifo_serializer #(.DATA_WIDTH(DW), .MSB_FIRST(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fifo_serializer #(.DATA_WIDTH(DW), .MSB_FIRST(1'b0)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (bus_l)
    );

    assign bus_l.fifo_dout  = bus.fifo_dout;
    assign bus_l.fifo_empty = bus.fifo_empty;
    assign bus_l.ser_ready  = bus.ser_ready;

    int nvec  = 0;
    int nfail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    // FIFO model with registered dout, driven by the MSB-first instance's rd_en
    logic          push_req  = 1'b0;
    logic [DW-1:0] push_data = '0;
    logic [DW-1:0] fq[$];

    always @(posedge clk) begin
        if (bus.fifo_rd_en && fq.size() > 0) begin
            bus.fifo_dout <= fq.pop_front();
        end
        if (push_req) begin
            fq.push_back(push_data);
        end
        bus.fifo_empty <= (fq.size() == 0);
    end

    // Stream model: every popped word contributes its bits in order.
    ebit_t exp_m[$];
    ebit_t exp_l[$];

    always begin
        logic [DW-1:0] w;
        @(negedge clk);
        #2;
        if (rst) begin
            exp_m.delete();
            exp_l.delete();
        end else begin
            chk("rd_en_when_empty", 32'(bus.fifo_rd_en && bus.fifo_empty), 0);
            chk("rd_en_lsb_dut", 32'(bus_l.fifo_rd_en), 32'(bus.fifo_rd_en));
            chk("busy", 32'(bus.busy), 32'(exp_m.size() != 0));
            chk("valid_lsb_dut", 32'(bus_l.ser_valid), 32'(bus.ser_valid));
            if (bus.ser_valid) begin
                chk("spurious_bit", 32'(exp_m.size() != 0), 1);
                if (exp_m.size() != 0) begin
                    chk("ser_data", 32'(bus.ser_data), 32'(exp_m[0].b));
                    chk("ser_last", 32'(bus.ser_last), 32'(exp_m[0].l));
                    chk("ser_data_lsb", 32'(bus_l.ser_data), 32'(exp_l[0].b));
                    chk("ser_last_lsb", 32'(bus_l.ser_last), 32'(exp_l[0].l));
                    if (bus.ser_ready) begin
                        void'(exp_m.pop_front());
                        void'(exp_l.pop_front());
                    end
                end
            end else begin
                chk("last_without_valid", 32'(bus.ser_last), 0);
            end
            if (bus.fifo_rd_en && fq.size() > 0) begin
                w = fq[0];
                for (int i = 0; i < DW; i++) begin
                    exp_m.push_back(ebit_t'{b: w[DW-1-i], l: (i == DW-1)});
                    exp_l.push_back(ebit_t'{b: w[i],      l: (i == DW-1)});
                end
            end
        end
    end

    // Stimulus-side capture for hand-computed expectations
    logic cap_m[$];
    logic cap_l[$];
    logic cap_last[$];
    int   cap_cyc[$];
    int   rd_cnt = 0;
    int   cyc    = 0;

    task automatic clear_cap();
        cap_m.delete();
        cap_l.delete();
        cap_last.delete();
        cap_cyc.delete();
        rd_cnt = 0;
    endtask

    task automatic step(input logic r, input logic rdy, input logic push, input logic [DW-1:0] d);
        @(negedge clk);
        rst           = r;
        bus.ser_ready = rdy;
        push_req      = push;
        push_data     = d;
        #2;
        cyc++;
        if (!rst) begin
            if (bus.fifo_rd_en) rd_cnt++;
            if (bus.ser_valid && bus.ser_ready) begin
                cap_m.push_back(bus.ser_data);
                cap_last.push_back(bus.ser_last);
                cap_cyc.push_back(cyc);
            end
            if (bus_l.ser_valid && bus_l.ser_ready) cap_l.push_back(bus_l.ser_data);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, '0);
    endtask

    function automatic logic [7:0] pack_m(input int off);
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++) v[7-i] = (off + i < cap_m.size()) ? cap_m[off+i] : 1'b0;
        return v;
    endfunction

    function automatic logic [7:0] pack_l(input int off);
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++) v[7-i] = (off + i < cap_l.size()) ? cap_l[off+i] : 1'b0;
        return v;
    endfunction

    function automatic int cyc_at(input int i);
        return (i < cap_cyc.size()) ? cap_cyc[i] : -100;
    endfunction

    function automatic int n_last();
        int n = 0;
        foreach (cap_last[i]) if (cap_last[i]) n++;
        return n;
    endfunction

    initial begin
        int start;
        bus.ser_ready = 1'b0;

        // Reset
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        chk("rst_valid", 32'(bus.ser_valid), 0);
        chk("rst_data", 32'(bus.ser_data), 0);
        chk("rst_last", 32'(bus.ser_last), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_rd_en", 32'(bus.fifo_rd_en), 0);
        idle(2);

        // Single word A5
        clear_cap();
        step(1'b0, 1'b1, 1'b1, 8'hA5);
        start = cyc;
        idle(12);
        chk("a5_bits", 32'(pack_m(0)), 32'h A5);
        chk("a5_count", 32'(cap_m.size()), 8);
        chk("a5_latency", 32'(cyc_at(0) - start), 3);
        chk("a5_contig", 32'(cyc_at(7) - cyc_at(0)), 7);
        chk("a5_last_pos", 32'(cap_last.size() == 8 && cap_last[7]), 1);
        chk("a5_last_count", 32'(n_last()), 1);
        chk("a5_rd_pulses", 32'(rd_cnt), 1);
        chk("a5_busy_after", 32'(bus.busy), 0);

        // Back-to-back F0, 0F
        clear_cap();
        step(1'b0, 1'b1, 1'b1, 8'hF0);
        step(1'b0, 1'b1, 1'b1, 8'h0F);
        idle(20);
        chk("b2b_bits", 32'({pack_m(0), pack_m(8)}), 32'h F00F);
        chk("b2b_count", 32'(cap_m.size()), 16);
        chk("b2b_no_gap", 32'(cyc_at(15) - cyc_at(0)), 15);
        chk("b2b_rd_pulses", 32'(rd_cnt), 2);

        // Backpressure on bit 3 of C3 for 5 cycles
        clear_cap();
        for (int k = 0; k < 24; k++) begin
            logic rdy;
            rdy = !(k >= 6 && k <= 10);
            step(1'b0, rdy, k == 0, 8'hC3);
            if (!rdy) begin
                chk("bp_valid", 32'(bus.ser_valid), 1);
                chk("bp_data", 32'(bus.ser_data), 0);
                chk("bp_last", 32'(bus.ser_last), 0);
                chk("bp_rd_en", 32'(bus.fifo_rd_en), 0);
            end
        end
        chk("bp_bits", 32'(pack_m(0)), 32'h C3);
        chk("bp_count", 32'(cap_m.size()), 8);
        chk("bp_rd_pulses", 32'(rd_cnt), 1);

        // Late fill: 81 arrives for the last-bit cycle of 3C
        clear_cap();
        for (int k = 0; k < 26; k++) begin
            step(1'b0, 1'b1, (k == 0) || (k == 9), (k == 0) ? 8'h3C : 8'h81);
        end
        chk("late_word1", 32'(pack_m(0)), 32'h 3C);
        chk("late_word2", 32'(pack_m(8)), 32'h 81);
        chk("late_gap", 32'(cyc_at(8) - cyc_at(7)), 2);
        chk("late_rd_pulses", 32'(rd_cnt), 2);

        // Reset at bit 4 of FF with 55 waiting in the FIFO
        clear_cap();
        for (int k = 0; k < 30; k++) begin
            step((k == 7) || (k == 8), 1'b1, (k == 0) || (k == 1), (k == 0) ? 8'hFF : 8'h55);
            if (k == 8) begin
                chk("mid_rst_valid", 32'(bus.ser_valid), 0);
                chk("mid_rst_data", 32'(bus.ser_data), 0);
                chk("mid_rst_last", 32'(bus.ser_last), 0);
                chk("mid_rst_busy", 32'(bus.busy), 0);
                chk("mid_rst_rd_en", 32'(bus.fifo_rd_en), 0);
                clear_cap();
            end
        end
        chk("post_rst_word", 32'(pack_m(0)), 32'h 55);
        chk("post_rst_count", 32'(cap_m.size()), 8);
        chk("post_rst_rd", 32'(rd_cnt), 1);

        // Reset while a prefetched word (99) is pending: it is dropped
        clear_cap();
        for (int k = 0; k < 36; k++) begin
            logic push;
            logic [7:0] d;
            push = (k == 0) || (k == 1) || (k == 14);
            d    = (k == 0) ? 8'h3C : ((k == 1) ? 8'h99 : 8'h5A);
            step((k == 11) || (k == 12), !(k == 10 || k == 11), push, d);
            if (k == 10) begin
                chk("pf_stall_last", 32'(bus.ser_last), 1);
                chk("pf_stall_rd_en", 32'(bus.fifo_rd_en), 0);
                chk("pf_stall_busy", 32'(bus.busy), 1);
            end
            if (k == 12) clear_cap();
        end
        chk("lost_read_word", 32'(pack_m(0)), 32'h 5A);
        chk("lost_read_count", 32'(cap_m.size()), 8);

        // Bit order of both instances with 01
        clear_cap();
        step(1'b0, 1'b1, 1'b1, 8'h01);
        idle(12);
        chk("msb_first_01", 32'(pack_m(0)), 32'h 01);
        chk("lsb_first_01", 32'(pack_l(0)), 32'h 80);
        chk("lsb_count", 32'(cap_l.size()), 8);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
